// File: rtl/ports_serializer_pkg.sv
// Shared types and helpers for the ports serializer: FSM state encoding,
// counter sizing and the even-parity function used when PORTS_SER_PARITY_EN is set.
package ports_ser_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } ser_state_t;

  // Wide enough for WIDTH itself, which the parity-extended frame needs.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  function automatic int gap_width(input int g);
    return (g < 1) ? 1 : $clog2(g + 1);
  endfunction

  function automatic logic even_parity(input logic [31:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/ports_serializer_if.sv
// Parallel word handshake into the serializer: the producer drives data/valid,
// the serializer answers with ready.
interface ports_ser_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/ports_serializer_shreg.sv
// Left-shifting register with parallel load; load takes priority over shift
// and the MSB is the bit currently on the serial line.
module ports_ser_shreg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] load_data,
  output logic         msb
);

  logic [W-1:0] shreg;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= load_data;
    end else if (shift) begin
      shreg <= {shreg[W-2:0], 1'b0};
    end
  end

  assign msb = shreg[W-1];

endmodule

// File: rtl/ports_serializer.sv
// Parallel-to-serial feeder: accepts a WIDTH-bit word and emits it MSB-first
// with frame/last strobes. Define PORTS_SER_PARITY_EN to append an even-parity bit.
module ports_serializer
  import ports_ser_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int IDLE_GAP = 1
) (
  input  logic           clk,
  input  logic           rstn,
  ports_ser_if.slave     in_if,
  output logic           out_bit,
  output logic           out_frame,
  output logic           out_last,
  output logic           busy
);

`ifdef PORTS_SER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif

  localparam int CW = cnt_width(WIDTH);
  localparam int GW = gap_width(IDLE_GAP);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_LEN - 1);
  localparam logic [GW-1:0] GAP_LOAD = GW'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

  ser_state_t           state;
  logic [CW-1:0]        cnt;
  logic [GW-1:0]        gap_cnt;
  logic                 accept;
  logic                 shreg_msb;
  logic [FRAME_LEN-1:0] load_word;

  assign in_if.in_ready = (state == IDLE);
  assign accept         = in_if.in_valid && (state == IDLE);

  // With parity enabled the parity bit rides in the LSB and reaches the MSB last.
`ifdef PORTS_SER_PARITY_EN
  assign load_word = {in_if.in_data, even_parity(32'(in_if.in_data))};
`else
  assign load_word = in_if.in_data;
`endif

  ports_ser_shreg #(
    .W (FRAME_LEN)
  ) u_shreg (
    .clk       (clk),
    .rstn      (rstn),
    .load      (accept),
    .shift     (state == SHIFT),
    .load_data (load_word),
    .msb       (shreg_msb)
  );

  assign out_bit = out_frame & shreg_msb;

  // Strobes are registered one step ahead so they line up with the bit the
  // shift register presents in the same cycle.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      gap_cnt   <= '0;
      out_frame <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_if.in_valid) begin
            state     <= SHIFT;
            cnt       <= CNT_LOAD;
            out_frame <= 1'b1;
            out_last  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        SHIFT: begin
          if (cnt == '0) begin
            out_frame <= 1'b0;
            out_last  <= 1'b0;
            if (IDLE_GAP > 0) begin
              state   <= GAP;
              gap_cnt <= GAP_LOAD;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt      <= cnt - CW'(1);
            out_last <= (cnt == CW'(1));
          end
        end
        GAP: begin
          if (gap_cnt == '0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end
        default: begin
          state     <= IDLE;
          out_frame <= 1'b0;
          out_last  <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
